// File: rtl/clk_en_gen.sv
// Lock-qualified reset sequencer plus NUM_CH programmable clock-enable dividers.
// Optional lock-loss statistics (lock_loss_cnt / stat_clr) built when CLK_EN_GEN_LOCK_STAT_EN is defined.

module clk_en_gen_ch #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 49
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             advance,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             ch_en,
  output logic             ch_clk
);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             en_q, en_d;
  logic             tog_q, tog_d;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    en_d   = 1'b0;
    tog_d  = tog_q;
    if (!advance) begin
      cnt_d = '0;
      act_d = pend_q;
      tog_d = 1'b0;
    end else if (cnt_q == act_q) begin
      // Period boundary: the only point a new divide value may take effect.
      cnt_d = '0;
      act_d = pend_q;
      en_d  = 1'b1;
      tog_d = ~tog_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cfg_load) pend_d = cfg_div;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      act_q  <= DIV_RST;
      pend_q <= DIV_RST;
      en_q   <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      en_q   <= en_d;
      tog_q  <= tog_d;
    end
  end

  assign ch_en  = en_q;
  assign ch_clk = tog_q;
endmodule

module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILT   = 1024,
  parameter int RST_HOLD    = 64,
  parameter int DIV_DEFAULT = 49
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
`ifdef CLK_EN_GEN_LOCK_STAT_EN
  input  logic                    stat_clr,
  output logic [7:0]              lock_loss_cnt,
`endif
  output logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_clk,
  output logic                    rst_out,
  output logic                    ready
);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {IDLE, FILTER, HOLD, RUN} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, lk_s_q;
  logic [FW-1:0] filt_q, filt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rst_out_q, rst_out_d;
  logic          ready_q, ready_d;
  logic          ch_adv;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = '0;
    hold_d  = '0;
    unique case (state_q)
      IDLE:    if (lk_s_q) state_d = FILTER;
      FILTER: begin
        if (!lk_s_q)                state_d = IDLE;
        else if (filt_q == FILT_LAST) state_d = HOLD;
        else                        filt_d  = filt_q + 1'b1;
      end
      HOLD: begin
        if (!lk_s_q)                state_d = IDLE;
        else if (hold_q == HOLD_LAST) state_d = RUN;
        else                        hold_d  = hold_q + 1'b1;
      end
      RUN:     if (!lk_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      filt_q    <= '0;
      hold_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;

  // Channels start one cycle after RUN is entered and clear on the edge that leaves it.
  assign ch_adv = (state_q == RUN) && (state_d == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_gen_ch #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .advance  (ch_adv),
      .cfg_load (cfg_load),
      .cfg_div  (div_cfg[i*DIV_W +: DIV_W]),
      .ch_en    (ch_en[i]),
      .ch_clk   (ch_clk[i])
    );
  end

`ifdef CLK_EN_GEN_LOCK_STAT_EN
  logic [7:0] loss_q, loss_d;
  logic       lock_loss;

  always_comb begin
    lock_loss = (state_q == RUN) && !lk_s_q;
    loss_d    = loss_q;
    if (stat_clr)                        loss_d = {7'd0, lock_loss};
    else if (lock_loss && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) loss_q <= '0;
    else         loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`endif
endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: directed vectors, corner sequences and a
// randomized run checked every cycle against a lock-run-length / strobe-timestamp model.
module tb_clk_en_gen;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int LF     = 8;
  localparam int RH     = 4;
  localparam int DEF    = 49;
  localparam int RUN_LEN = LF + RH + 1;
  // Both synchroniser stages restart at 0, so lock is seen two edges late.
  localparam int LOCK_LAT = LF + RH + 1 + 2;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst, pll_locked, cfg_load, cfg_load2;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic [7:0]              div_cfg2;
  logic [NUM_CH-1:0]       ch_en, ch_clk;
  logic                    rst_out, ready;
  logic [0:0]              ch_en2, ch_clk2;
  logic                    rst_out2, ready2;
`ifdef CLK_EN_GEN_LOCK_STAT_EN
  logic                    stat_clr;
  logic [7:0]              lock_loss_cnt, lock_loss_cnt2;
`endif

  always #5 sys_clk = ~sys_clk;

  clk_en_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILT(LF), .RST_HOLD(RH), .DIV_DEFAULT(DEF)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pll_locked(pll_locked), .div_cfg(div_cfg), .cfg_load(cfg_load),
`ifdef CLK_EN_GEN_LOCK_STAT_EN
    .stat_clr(stat_clr), .lock_loss_cnt(lock_loss_cnt),
`endif
    .ch_en(ch_en), .ch_clk(ch_clk), .rst_out(rst_out), .ready(ready));

  // Narrow single-channel instance exercises the all-ones divide boundary cheaply.
  clk_en_gen #(.NUM_CH(1), .DIV_W(8), .LOCK_FILT(LF), .RST_HOLD(RH), .DIV_DEFAULT(255)) u_dut_w8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pll_locked(pll_locked), .div_cfg(div_cfg2), .cfg_load(cfg_load2),
`ifdef CLK_EN_GEN_LOCK_STAT_EN
    .stat_clr(stat_clr), .lock_loss_cnt(lock_loss_cnt2),
`endif
    .ch_en(ch_en2), .ch_clk(ch_clk2), .rst_out(rst_out2), .ready(ready2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: RUN holds once lk_s has been high for RUN_LEN consecutive
  // edges; each channel strobes at an absolute timestamp set one period ahead.
  longint cyc = 0;
  int     runlen = 0;
  bit     run_m = 0, run_p = 0;
  bit     sync_m[2];
  int     act_m[NUM_CH], pend_m[NUM_CH];
  longint nxt_m[NUM_CH];
  logic [NUM_CH-1:0] en_m = '0, clk_m = '0;
  int     loss_m = 0;

  task automatic model_step();
    bit lks, lost;
    cyc++;
    if (sys_rst) begin
      runlen = 0; run_m = 0; run_p = 0; sync_m[0] = 0; sync_m[1] = 0;
      en_m = '0; clk_m = '0; loss_m = 0;
      for (int c = 0; c < NUM_CH; c++) begin act_m[c] = DEF; pend_m[c] = DEF; nxt_m[c] = 0; end
      return;
    end
    lks = sync_m[1];
    sync_m[1] = sync_m[0];
    sync_m[0] = pll_locked;
    run_p  = run_m;
    runlen = lks ? ((runlen < RUN_LEN) ? runlen + 1 : runlen) : 0;
    run_m  = (runlen >= RUN_LEN);
    lost   = run_p && !run_m;
    for (int c = 0; c < NUM_CH; c++) begin
      en_m[c] = 1'b0;
      if (run_m && !run_p) begin
        act_m[c] = pend_m[c]; nxt_m[c] = cyc + act_m[c] + 1; clk_m[c] = 1'b0;
      end else if (run_m && run_p) begin
        if (cyc == nxt_m[c]) begin
          en_m[c] = 1'b1; clk_m[c] = ~clk_m[c];
          act_m[c] = pend_m[c]; nxt_m[c] = cyc + act_m[c] + 1;
        end
      end else begin
        act_m[c] = pend_m[c]; clk_m[c] = 1'b0;
      end
    end
    if (cfg_load)
      for (int c = 0; c < NUM_CH; c++) pend_m[c] = int'(div_cfg[c*DIV_W +: DIV_W]);
`ifdef CLK_EN_GEN_LOCK_STAT_EN
    if (stat_clr)                 loss_m = lost ? 1 : 0;
    else if (lost && loss_m < 255) loss_m++;
`else
    if (lost) loss_m++;
`endif
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    chk("rst_out", rst_out, !run_m);
    chk("ready", ready, run_m);
    chk("ch_en", ch_en, en_m);
    chk("ch_clk", ch_clk, clk_m);
    chk("rst_out_w8", rst_out2, !run_m);
`ifdef CLK_EN_GEN_LOCK_STAT_EN
    chk("lock_loss_cnt", lock_loss_cnt, loss_m);
`endif
  endtask

  task automatic wait_en(input int c, output int n);
    n = 0;
    while (ch_en[c] !== 1'b1 && n < 1000) begin tick(); n++; end
  endtask

  task automatic en_interval(input int c, output int n);
    n = 0;
    do begin tick(); n++; end while (ch_en[c] !== 1'b1 && n < 1000);
  endtask

  task automatic clk_period(input int c, output int n);
    int g = 0;
    while (ch_clk[c] !== 1'b0 && g < 1000) begin tick(); g++; end
    while (ch_clk[c] !== 1'b1 && g < 2000) begin tick(); g++; end
    n = 0;
    do begin tick(); n++; end while (ch_clk[c] !== 1'b0 && n < 1000);
    do begin tick(); n++; end while (ch_clk[c] !== 1'b1 && n < 2000);
  endtask

  task automatic relock();
    int n = 0;
    pll_locked = 1'b1;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    chk("relock_ready", ready, 1);
  endtask

  task automatic lose_lock();
    pll_locked = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct { int ch; int div; int en_per; int clk_per; } vec_t;
  vec_t tbl[4];

  initial begin
    int n, t, early;
    tbl[0] = '{0, 0, 1, 2};
    tbl[1] = '{1, 1, 2, 4};
    tbl[2] = '{2, 9, 10, 20};
    tbl[3] = '{3, 49, 50, 100};

    sys_rst = 1'b1; pll_locked = 1'b1; cfg_load = 1'b0; cfg_load2 = 1'b0; div_cfg2 = 8'd0;
    for (int c = 0; c < NUM_CH; c++) div_cfg[c*DIV_W +: DIV_W] = 16'(DEF);
`ifdef CLK_EN_GEN_LOCK_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_rst_out", rst_out, 1);
    chk("reset_ready", ready, 0);
    chk("reset_ch_en", ch_en, 0);

    // Startup sequence and first strobes.
    sys_rst = 1'b0;
    n = 0;
    while (rst_out === 1'b1 && n < 100) begin tick(); n++; end
    chk("startup_latency", n, LOCK_LAT);
    chk("startup_ready", ready, 1);
    n = 0;
    while (ch_en[0] !== 1'b1 && n < 300) begin tick(); n++; end
    chk("first_en_ch0", n, DEF + 1);
    while (ch_en2[0] !== 1'b1 && n < 600) begin tick(); n++; end
    chk("first_en_w8", n, 256);
    n = 0;
    do begin tick(); n++; end while (ch_en2[0] !== 1'b1 && n < 600);
    chk("en_period_w8", n, 256);
    t = 0;
    while (ch_clk2[0] !== 1'b0 && t < 600) begin tick(); t++; end
    while (ch_clk2[0] !== 1'b1 && t < 1200) begin tick(); t++; end
    n = 0;
    do begin tick(); n++; end while (ch_clk2[0] !== 1'b0 && n < 600);
    do begin tick(); n++; end while (ch_clk2[0] !== 1'b1 && n < 1200);
    chk("clk_period_w8", n, 512);

    // Lock loss in RUN, reload divides, full relock.
    pll_locked = 1'b0;
    repeat (2) tick();
    chk("loss_sync_delay", rst_out, 0);
    tick();
    chk("loss_rst_out", rst_out, 1);
    chk("loss_ready", ready, 0);
    chk("loss_ch_en", ch_en, 0);
    chk("loss_ch_clk", ch_clk, 0);
    for (int i = 0; i < 4; i++) div_cfg[tbl[i].ch*DIV_W +: DIV_W] = 16'(tbl[i].div);
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    while (rst_out === 1'b1 && n < 100) begin tick(); n++; end
    chk("relock_latency", n, LOCK_LAT);
    for (int i = 0; i < 4; i++) begin
      wait_en(tbl[i].ch, n);
      en_interval(tbl[i].ch, n);
      chk("tbl_en_period", n, tbl[i].en_per);
      clk_period(tbl[i].ch, n);
      chk("tbl_clk_period", n, tbl[i].clk_per);
    end

    // Mid-period update on ch1: 10-cycle period finishes, then 4-cycle periods.
    div_cfg[DIV_W +: DIV_W] = 16'd9; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    tick();
    wait_en(1, n);
    repeat (4) tick();
    div_cfg[DIV_W +: DIV_W] = 16'd3; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    t = 5;
    while (ch_en[1] !== 1'b1 && t < 100) begin tick(); t++; end
    chk("upd_mid_current", t, 10);
    en_interval(1, n); chk("upd_mid_next", n, 4);
    en_interval(1, n); chk("upd_mid_next2", n, 4);

    // Update landing on the strobe cycle.
    div_cfg[DIV_W +: DIV_W] = 16'd9; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    wait_en(1, n);
    div_cfg[DIV_W +: DIV_W] = 16'd3; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    t = 1;
    while (ch_en[1] !== 1'b1 && t < 100) begin tick(); t++; end
    chk("upd_wrap_current", t, 10);
    en_interval(1, n); chk("upd_wrap_next", n, 4);

    // Lock glitch while filtering: counter must restart from scratch.
    lose_lock();
    pll_locked = 1'b1; early = 0;
    repeat (8) begin tick(); if (rst_out !== 1'b1) early++; end
    pll_locked = 1'b0;
    repeat (3) begin tick(); if (rst_out !== 1'b1) early++; end
    pll_locked = 1'b1; n = 0;
    while (rst_out === 1'b1 && n < 100) begin tick(); n++; end
    chk("glitch_no_early_release", early, 0);
    chk("glitch_relock_latency", n, LOCK_LAT);

    // Synchronous reset in RUN.
    repeat (20) tick();
    sys_rst = 1'b1; tick();
    chk("midrun_rst_out", rst_out, 1);
    chk("midrun_ready", ready, 0);
    chk("midrun_ch_en", ch_en, 0);
    chk("midrun_ch_clk", ch_clk, 0);
    sys_rst = 1'b0;

`ifdef CLK_EN_GEN_LOCK_STAT_EN
    chk("stat_reset", lock_loss_cnt, 0);
    repeat (3) begin relock(); lose_lock(); end
    chk("stat_three", lock_loss_cnt, 3);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    chk("stat_clear", lock_loss_cnt, 0);
    repeat (300) begin relock(); lose_lock(); end
    chk("stat_saturate", lock_loss_cnt, 255);
    relock();
    pll_locked = 1'b0; tick(); tick();
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    chk("stat_clr_with_loss", lock_loss_cnt, 1);
`endif

    // Randomized run against the model.
    pll_locked = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (pll_locked) begin if ($urandom_range(0, 199) == 0) pll_locked = 1'b0; end
      else if ($urandom_range(0, 2) == 0) pll_locked = 1'b1;
      sys_rst  = ($urandom_range(0, 999) == 0);
      cfg_load = ($urandom_range(0, 19) == 0);
      if (cfg_load)
        for (int c = 0; c < NUM_CH; c++) div_cfg[c*DIV_W +: DIV_W] = 16'($urandom_range(0, 12));
`ifdef CLK_EN_GEN_LOCK_STAT_EN
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end
    sys_rst = 1'b0; cfg_load = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
